xor_share_arbiter: RTL
======================

Name: xor_share_arbiter

Overview:
- Shares one gated-XOR datapath unit among N_REQ requesters using round-robin arbitration. The unit computes q = en ? a^b : 0.
- Per request: latches the winner's operands, drives dp_en/dp_a/dp_b for one cycle, captures dp_q, and returns the result with a one-cycle done pulse.
- Sits between requester blocks and the single shared XOR unit instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits

Ports:
- clk  input  1  system clock; all logic on posedge clk
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  per-requester request level; held until its done bit pulses
- a_in  input  N_REQ*W  operand A; requester i occupies bits [i*W +: W]
- b_in  input  N_REQ*W  operand B, same packing as a_in
- gnt  output  N_REQ  one-hot grant, registered
- done  output  N_REQ  one-hot, one-cycle completion pulse
- q_out  output  W  result for the requester whose done bit is high
- busy  output  1  high while in ST_ISSUE
- err  output  1  sticky datapath-check error
- dp_en  output  1  enable to the shared XOR unit
- dp_a  output  W  operand A to the shared unit
- dp_b  output  W  operand B to the shared unit
- dp_q  input  W  combinational result from the shared unit

Behaviour:
- Reset (rst=1 at posedge clk): state=ST_IDLE, ptr=0, and gnt, done, q_out, busy, err, dp_en, dp_a, dp_b all 0. Reset mid-operation aborts the operation; no done pulse is produced.
- ST_IDLE, any req bit high:
  - Winner = first set req bit scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Next edge: gnt=onehot(winner); dp_a/dp_b = winner's slices of a_in/b_in; dp_en=1; busy=1; state=ST_ISSUE; ptr=(winner+1) mod N_REQ.
- ST_IDLE, req all 0: outputs hold; dp_en=0, dp_a=0, dp_b=0.
- ST_ISSUE (exactly one cycle):
  - Next edge: q_out=dp_q; done=gnt; err |= (dp_q != dp_a^dp_b).
  - Also at that edge: gnt=0; dp_en=0; dp_a=0; dp_b=0; busy=0; state=ST_IDLE.
- done is high for exactly one cycle. q_out holds its value until the next completion.
- Latency: req sampled at edge k gives gnt/dp_en high after edge k, and done/q_out valid after edge k+1.
- Throughput: at most one operation every 2 cycles; no back-to-back issue.
- Operands are captured only at grant. Changes to a_in/b_in, or dropping req, during ST_ISSUE do not affect the result, and done still pulses.
- A requester whose req is still high in the cycle done pulses is re-eligible, but ptr has advanced past it, so other pending requesters win first.
- Simultaneous requests are resolved purely by ptr order; there is no fixed priority.
- err is cleared only by rst.

Decomposition:
- Shared header/package: state encodings ST_IDLE=1'b0, ST_ISSUE=1'b1; default N_REQ/W values; the slice-index convention for packed operand buses.
- One sub-module, rr_pick (combinational):
  - Inputs: req, ptr. Outputs: winner index, any_req.
  - Rotating-priority search, reusable by other arbiters.
- The shared XOR unit stays external and is instantiated beside this block.

Test Plan:
- Single request: req=0001, a0=8'hF0, b0=8'h3C. Expect gnt=0001 and dp_en=1 one cycle after sampling; next cycle done=0001, q_out=8'hCC; err=0.
- Contention: req=1111 held continuously, distinct operands. Expect grant order 0,1,2,3,0. Each done pulse carries its own requester's a^b. Operations are spaced exactly 2 cycles apart.
- Wrap and skip: ptr=2 after a prior grant to requester 1, req=0011. Expect grant to 0, then 1; requesters 2 and 3 are never granted.
- Operand change and req drop after grant: a1 changes from 8'h01 to 8'hFF during ST_ISSUE and req1 falls. Expect q_out = original 8'h01^b1 and done=0010 still pulses.
- Reset mid-op: rst=1 during ST_ISSUE. Expect no done pulse; all outputs 0 next cycle; with req=0100 afterwards, grant goes to 2 (ptr reset to 0).
- Faulty unit: model dp_q = a^b^8'h01 for one operation. Expect err=1, and err stays 1 after later correct operations until rst.

Source files
------------

// File: rtl/xor_share_arbiter_pkg.sv
// Shared definitions for the XOR-unit sharing arbiter.
package xor_share_arbiter_pkg;

    // Default sizing
    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;

    // Controller state encoding
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Packed operand buses place requester idx at bits [idx*w +: w]
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/xor_share_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, ... mod N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    // Walk the ring starting at ptr, keep the first hit
    always_comb begin
        logic found;
        int   idx;
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one external gated-XOR unit among N_REQ requesters.
module xor_share_arbiter
    import xor_share_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       q_out,
    output logic               busy,
    output logic               err,
    output logic               dp_en,
    output logic [W-1:0]       dp_a,
    output logic [W-1:0]       dp_b,
    input  logic [W-1:0]       dp_q
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [N_REQ-1:0]   gnt_n, done_n;
    logic [W-1:0]       q_n, a_n, b_n;
    logic               busy_n, err_n, en_n;
    logic [IDX_W-1:0]   winner;
    logic               any_req;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Next-state and registered-output logic; done defaults low so it only pulses
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt;
        done_n  = '0;
        q_n     = q_out;
        busy_n  = busy;
        err_n   = err;
        en_n    = dp_en;
        a_n     = dp_a;
        b_n     = dp_b;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_n         = '0;
                    gnt_n[winner] = 1'b1;
                    a_n           = a_in[slice_lo(int'(winner), W) +: W];
                    b_n           = b_in[slice_lo(int'(winner), W) +: W];
                    en_n          = 1'b1;
                    busy_n        = 1'b1;
                    state_n       = ST_ISSUE;
                    ptr_n         = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
                end else begin
                    en_n = 1'b0;
                    a_n  = '0;
                    b_n  = '0;
                end
            end
            ST_ISSUE: begin
                // Operands were latched at grant, so late a_in/req changes are ignored
                q_n     = dp_q;
                done_n  = gnt;
                err_n   = err | (dp_q != (dp_a ^ dp_b));
                gnt_n   = '0;
                en_n    = 1'b0;
                a_n     = '0;
                b_n     = '0;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            gnt   <= '0;
            done  <= '0;
            q_out <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
            dp_en <= 1'b0;
            dp_a  <= '0;
            dp_b  <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            gnt   <= gnt_n;
            done  <= done_n;
            q_out <= q_n;
            busy  <= busy_n;
            err   <= err_n;
            dp_en <= en_n;
            dp_a  <= a_n;
            dp_b  <= b_n;
        end
    end

endmodule
